// File: rtl/ta_bank_update.sv
// Bank of Tsetlin automata with a serial, one-TA-per-cycle feedback update engine.
// Optional feature: define TA_STATE_READ_EN to add the rd_idx/rd_state readback port.
module ta_bank_update #(
  parameter int unsigned N_TA       = 4,
  parameter int unsigned STATE_BITS = 3,
  localparam int unsigned IDX_W     = (N_TA > 1) ? $clog2(N_TA) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fb_valid,
  output logic                  fb_ready,
  input  logic [2*N_TA-1:0]     fb_vec,
  output logic                  busy,
  output logic                  done,
  output logic [N_TA-1:0]       action
`ifdef TA_STATE_READ_EN
  ,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [STATE_BITS-1:0] rd_state
`endif
);

  localparam int unsigned FB_W = 2 * N_TA;
  localparam logic [STATE_BITS-1:0] ST_MAX    = '1;
  localparam logic [STATE_BITS-1:0] ST_ZERO   = '0;
  localparam logic [STATE_BITS-1:0] ST_MID_M1 = ST_MAX >> 1;
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(N_TA - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_DONE
  } fsm_t;

  fsm_t                  state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FB_W-1:0]       cap_q, cap_d;
  logic                  upd_en;
  logic [STATE_BITS-1:0] ta_q [N_TA];
  logic [STATE_BITS-1:0] ta_d [N_TA];
  logic [STATE_BITS-1:0] cur_st;
  logic [STATE_BITS-1:0] new_st;
  logic [1:0]            cur_code;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, sweep index and vector capture
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    upd_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fb_valid) begin
          cap_d   = fb_vec;
          idx_d   = '0;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        upd_en = 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Select the TA and feedback code addressed by the sweep index
  always_comb begin
    cur_st   = '0;
    cur_code = 2'b00;
    for (int i = 0; i < int'(N_TA); i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_st   = ta_q[i];
        cur_code = cap_q[2*i +: 2];
      end
    end
  end

  // Shared inc/dec: reward reinforces the current action, penalty pushes toward the other
  always_comb begin
    new_st = cur_st;
    case (cur_code)
      2'b01: begin
        if (cur_st[STATE_BITS-1]) begin
          if (cur_st != ST_MAX) new_st = cur_st + STATE_BITS'(1);
        end else begin
          if (cur_st != ST_ZERO) new_st = cur_st - STATE_BITS'(1);
        end
      end
      2'b10: begin
        new_st = cur_st[STATE_BITS-1] ? cur_st - STATE_BITS'(1) : cur_st + STATE_BITS'(1);
      end
      default: begin
        new_st = cur_st;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < int'(N_TA); i++) begin
      ta_d[i] = (upd_en && (idx_q == IDX_W'(i))) ? new_st : ta_q[i];
    end
  end

  // Datapath registers and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= '0;
      cap_q    <= '0;
      fb_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < int'(N_TA); i++) begin
        ta_q[i] <= ST_MID_M1;
      end
    end else begin
      idx_q    <= idx_d;
      cap_q    <= cap_d;
      fb_ready <= (state_d == S_IDLE);
      busy     <= (state_d != S_IDLE);
      done     <= (state_d == S_DONE);
      for (int i = 0; i < int'(N_TA); i++) begin
        ta_q[i] <= ta_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N_TA); i++) begin
      action[i] = ta_q[i][STATE_BITS-1];
    end
  end

`ifdef TA_STATE_READ_EN
  logic [STATE_BITS-1:0] rd_sel;

  // Read from the post-edge value so a commit on the same edge is visible
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < int'(N_TA); i++) begin
      if (rd_idx == IDX_W'(i)) rd_sel = ta_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= '0;
    end else begin
      rd_state <= rd_sel;
    end
  end
`endif

endmodule
